// File: rtl/highlight_overlay_if.sv
// Stream bundle between the highlight/RGB input FIFOs, the overlay stage and the output FIFO.
// The master drives FIFO heads, flags and start; the slave is the overlay engine.
interface highlight_overlay_if;
  localparam int unsigned HL_W  = 8;
  localparam int unsigned PIX_W = 24;

  logic             start;
  logic [HL_W-1:0]  highlight_dout;
  logic             highlight_empty;
  logic             highlight_rd_en;
  logic [PIX_W-1:0] image_dout;
  logic             image_empty;
  logic             image_rd_en;
  logic [PIX_W-1:0] out_din;
  logic             out_wr_en;
  logic             out_full;
  logic             frame_done;

  modport master (
    output start, highlight_dout, highlight_empty, image_dout, image_empty, out_full,
    input  highlight_rd_en, image_rd_en, out_din, out_wr_en, frame_done
  );

  modport slave (
    input  start, highlight_dout, highlight_empty, image_dout, image_empty, out_full,
    output highlight_rd_en, image_rd_en, out_din, out_wr_en, frame_done
  );
endinterface

// File: rtl/highlight_overlay.sv
// Pops highlight byte + RGB pixel pairs, paints edge pixels and pushes them to the output FIFO.
// HIGHLIGHT_OVERLAY_BLEND_EN: averages edge pixels with the colour instead of replacing them.
module highlight_overlay #(
  parameter int unsigned REDUCED_WIDTH   = 512,
  parameter int unsigned REDUCED_HEIGHT  = 288,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000
) (
  input logic                clock,
  input logic                reset,
  highlight_overlay_if.slave bus
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned N_CH  = PIX_W / CH_W;
  localparam int unsigned X_W   = (REDUCED_WIDTH  > 1) ? $clog2(REDUCED_WIDTH)  : 1;
  localparam int unsigned Y_W   = (REDUCED_HEIGHT > 1) ? $clog2(REDUCED_HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(REDUCED_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(REDUCED_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic               out_valid;
  logic [PIX_W-1:0]   out_data;
  logic               frame_done_q;

  logic               pop_c;
  logic               wr_c;
  logic               x_last_c;
  logic               last_px_c;

  // Edge pixels get the highlight colour; any non-zero highlight byte counts as an edge.
  function automatic logic [PIX_W-1:0] overlay(input logic [PIX_W-1:0] px,
                                               input logic [CH_W-1:0]  hl);
    logic [PIX_W-1:0] res;
    logic [CH_W:0]    sum;
    res = px;
    sum = '0;
    if (hl != '0) begin
`ifdef HIGHLIGHT_OVERLAY_BLEND_EN
      for (int c = 0; c < int'(N_CH); c++) begin
        sum = (CH_W+1)'(px[c*CH_W +: CH_W]) + (CH_W+1)'(HIGHLIGHT_COLOR[c*CH_W +: CH_W]);
        res[c*CH_W +: CH_W] = sum[CH_W:1];
      end
`else
      res = HIGHLIGHT_COLOR;
`endif
    end
    return res;
  endfunction

  assign x_last_c  = (x_q == X_LAST);
  assign last_px_c = x_last_c && (y_q == Y_LAST);
  assign wr_c      = out_valid && !bus.out_full;
  // The holding register may be refilled in the same cycle it is drained.
  assign pop_c     = (state == ST_RUN) && !bus.highlight_empty && !bus.image_empty &&
                     (!out_valid || !bus.out_full);

  assign bus.highlight_rd_en = pop_c;
  assign bus.image_rd_en     = pop_c;
  assign bus.out_din         = out_data;
  assign bus.out_wr_en       = wr_c;
  assign bus.frame_done      = frame_done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start)          state_nxt = ST_RUN;
      ST_RUN:   if (pop_c && last_px_c) state_nxt = ST_DRAIN;
      ST_DRAIN: if (wr_c)               state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Raster counters advance only on a pop and wrap to (0,0) after the last pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pop_c) begin
      if (last_px_c) begin
        x_q <= '0;
        y_q <= '0;
      end else if (x_last_c) begin
        x_q <= '0;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop_c) begin
      out_valid <= 1'b1;
      out_data  <= overlay(bus.image_dout, bus.highlight_dout);
    end else if (wr_c) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state == ST_DRAIN) && wr_c;
    end
  end

endmodule

// File: tb/tb_highlight_overlay.sv
// Scoreboard bench for highlight_overlay on a 4x2 frame with modelled FWFT input FIFOs.
module tb_highlight_overlay;

  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int          N_PIX = W * H;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  highlight_overlay_if bus ();

  highlight_overlay #(
    .REDUCED_WIDTH  (W),
    .REDUCED_HEIGHT (H),
    .HIGHLIGHT_COLOR(COLOR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [23:0] img_mem [N_PIX];
  logic [7:0]  hl_mem  [N_PIX];
  int          idx = 0;
  logic        img_stall = 1'b0;
  logic        hl_stall  = 1'b0;

  // FWFT FIFO heads: the entry at idx is visible whenever the FIFO is not empty.
  assign bus.image_dout      = (idx < N_PIX) ? img_mem[idx] : 24'h0;
  assign bus.highlight_dout  = (idx < N_PIX) ? hl_mem[idx]  : 8'h0;
  assign bus.image_empty     = img_stall || (idx >= N_PIX);
  assign bus.highlight_empty = hl_stall  || (idx >= N_PIX);

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] expq [$];
  int          wr_cycles [$];
  int          cyc = 0;
  int          done_seen = 0;
  bit          done_pending = 0;
  bit          idle_mode = 0;
  bit          popped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference overlay, worked per channel with plain integer arithmetic.
  function automatic logic [23:0] ref_overlay(input logic [23:0] px, input logic [7:0] hl);
    int r;
    if (hl == 8'd0) return px;
`ifdef HIGHLIGHT_OVERLAY_BLEND_EN
    r = 0;
    for (int c = 0; c < 3; c++) begin
      r += (((int'(px) >> (8*c)) & 255) + ((int'(COLOR) >> (8*c)) & 255)) / 2 << (8*c);
    end
    return 24'(r);
`else
    r = int'(COLOR);
    return 24'(r);
`endif
  endfunction

  always @(posedge clock) cyc++;

  // Monitor: pops the scoreboard on every accepted write and tracks frame_done timing.
  always @(negedge clock) begin
    if (reset) begin
      done_pending = 0;
    end else begin
      check("frame_done_timing", 32'(bus.frame_done), 32'(done_pending));
      done_pending = 0;
      if (bus.frame_done) done_seen++;
      check("rd_en_pair", 32'(bus.highlight_rd_en), 32'(bus.image_rd_en));
      if (idle_mode)
        check("idle_activity",
              32'({bus.highlight_rd_en, bus.image_rd_en, bus.out_wr_en, bus.frame_done}), 32'h0);
      if (bus.out_full)
        check("write_while_full", 32'(bus.out_wr_en), 32'h0);
      if (bus.out_wr_en) begin
        check("write_expected", 32'(expq.size() != 0), 32'h1);
        if (expq.size() != 0) begin
          check("out_din", 32'(bus.out_din), 32'(expq.pop_front()));
          wr_cycles.push_back(cyc);
          if (expq.size() == 0) done_pending = 1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    popped = bus.image_rd_en;
    @(posedge clock);
    #1;
    if (popped) idx++;
  endtask

  // kind 0: directed ramp, 1: random, 2: random with a fixed blend probe at pixel 0.
  task automatic load_frame(input int kind);
    logic [23:0] e;
    for (int i = 0; i < N_PIX; i++) begin
      if (kind == 0) begin
        img_mem[i] = 24'h000010 + 24'(i);
        hl_mem[i]  = (i % 2 == 0) ? 8'h00 : ((i % 4 == 1) ? 8'hFF : 8'h01);
      end else begin
        img_mem[i] = 24'($urandom);
        hl_mem[i]  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      end
    end
    if (kind == 2) begin
      img_mem[0] = 24'h204060;
      hl_mem[0]  = 8'hFF;
    end
    idx = 0;
    for (int i = 0; i < N_PIX; i++) begin
      e = ref_overlay(img_mem[i], hl_mem[i]);
`ifdef HIGHLIGHT_OVERLAY_BLEND_EN
      if (kind == 2 && i == 0) e = 24'h8F2030;
`else
      if (kind == 2 && i == 0) e = 24'hFF0000;
`endif
      expq.push_back(e);
    end
  endtask

  task automatic stall5();
    logic [23:0] held;
    bus.out_full = 1'b1;
    img_stall = 1'b0;
    hl_stall  = 1'b0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) held = bus.out_din;
      else check("stall_out_din_frozen", 32'(bus.out_din), 32'(held));
      check("stall_no_pop", 32'(bus.highlight_rd_en | bus.image_rd_en), 32'h0);
      popped = bus.image_rd_en;
      @(posedge clock);
      #1;
      if (popped) idx++;
    end
    bus.out_full = 1'b0;
  endtask

  task automatic run_frame(input int kind, input int img_p, input int hl_p, input int full_p,
                           input bit do_stall);
    int  t0;
    bit  stalled;
    load_frame(kind);
    t0 = done_seen;
    wr_cycles.delete();
    stalled = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 3000 && done_seen == t0; n++) begin
      if (do_stall && !stalled && wr_cycles.size() == 3) begin
        stall5();
        stalled = 1;
      end
      img_stall    = ($urandom_range(99) < 32'(img_p));
      hl_stall     = ($urandom_range(99) < 32'(hl_p));
      bus.out_full = ($urandom_range(99) < 32'(full_p));
      // start pulses while running must be ignored; kept clear of the frame end
      bus.start    = (kind == 1 && idx < N_PIX - 1) ? 1'($urandom_range(1)) : 1'b0;
      tick();
    end
    bus.out_full = 1'b0;
    bus.start    = 1'b0;
    img_stall    = 1'b0;
    hl_stall     = 1'b0;
    check("frame_done_count", 32'(done_seen - t0), 32'd1);
    check("frame_leftover", 32'(expq.size()), 32'd0);
    check("frame_consumed", 32'(idx), 32'(N_PIX));
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.out_full = 1'b0;
    for (int i = 0; i < N_PIX; i++) begin
      img_mem[i] = '0;
      hl_mem[i]  = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_out_wr_en", 32'(bus.out_wr_en), 32'h0);
    check("reset_out_din", 32'(bus.out_din), 32'h0);
    check("reset_frame_done", 32'(bus.frame_done), 32'h0);
    check("reset_rd_en", 32'(bus.highlight_rd_en | bus.image_rd_en), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle with both FIFOs holding data but no start.
    load_frame(1);
    expq.delete();
    idle_mode = 1;
    repeat (20) tick();
    idle_mode = 0;
    check("idle_no_consume", 32'(idx), 32'd0);

    // Directed frame, everything ready: eight back-to-back writes.
    run_frame(0, 0, 0, 0, 0);
    check("directed_write_count", 32'(wr_cycles.size()), 32'd8);
    if (wr_cycles.size() == 8)
      check("directed_back_to_back", 32'(wr_cycles[7] - wr_cycles[0]), 32'd7);

    // Output FIFO full for five cycles mid-frame.
    run_frame(0, 0, 0, 0, 1);

    // Blend / replace probe.
    run_frame(2, 0, 0, 0, 0);

    // Randomized back-pressure and input starvation.
    for (int f = 0; f < 4; f++) run_frame(1, 40, 0, 0, 0);
    for (int f = 0; f < 4; f++) run_frame(1, 0, 40, 0, 0);
    for (int f = 0; f < 4; f++) run_frame(1, 0, 0, 50, 0);
    for (int f = 0; f < 6; f++) run_frame(1, 30, 30, 30, 0);

    // Reset after the third pop, then a clean frame from (0,0).
    load_frame(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 100 && idx < 3; n++) tick();
    check("reached_pixel3", 32'(idx), 32'd3);
    reset = 1'b1;
    #1;
    check("midreset_out_wr_en", 32'(bus.out_wr_en), 32'h0);
    check("midreset_out_din", 32'(bus.out_din), 32'h0);
    check("midreset_rd_en", 32'(bus.highlight_rd_en | bus.image_rd_en), 32'h0);
    check("midreset_frame_done", 32'(bus.frame_done), 32'h0);
    expq.delete();
    done_pending = 0;
    idx = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_frame(1, 0, 0, 0, 0);
    run_frame(1, 20, 20, 20, 0);

    idle_mode = 1;
    repeat (10) tick();
    idle_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
